// File: rtl/net_so_controller.sv
// Multi-channel network send/receive controller between the core and the Arduino link.
// Handles handshaked TX with timeout and per-channel RX FIFOs with sticky overflow flags.
module net_so_controller #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 1023,
    localparam int unsigned CH_W      = $clog2(NUM_CH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              send_req,
    input  logic [CH_W-1:0]   send_dest,
    input  logic [DATA_W-1:0] send_data,
    input  logic              recv_req,
    input  logic [CH_W-1:0]   recv_ch,
    output logic              busy,
    output logic              send_done,
    output logic              timeout_err,
    output logic              recv_valid,
    output logic              recv_empty,
    output logic [DATA_W-1:0] recv_data,
    output logic [1:0]        addr_so_control,
    output logic              tx_valid,
    output logic [CH_W-1:0]   tx_dest,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ack,
    input  logic              rx_valid,
    input  logic [CH_W-1:0]   rx_src,
    input  logic [DATA_W-1:0] rx_data,
    output logic [NUM_CH-1:0] overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND_WAIT, RECV} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     wait_cnt, wait_cnt_nx;
    logic [CH_W-1:0]   rd_ch, rd_ch_nx;
    logic              busy_nx, send_done_nx, timeout_err_nx;
    logic              recv_valid_nx, recv_empty_nx, tx_valid_nx;
    logic [DATA_W-1:0] recv_data_nx, tx_data_nx;
    logic [CH_W-1:0]   tx_dest_nx;
    logic [1:0]        mode_nx;

    logic [PW-1:0]     wptr [NUM_CH];
    logic [PW-1:0]     rptr [NUM_CH];
    logic [DATA_W-1:0] mem  [NUM_CH][FIFO_DEPTH];
    logic [NUM_CH-1:0] empty_c, full_c;
    logic              pop_c, push_c, drop_full_c, rx_in_range_c, rd_in_range_c, same_ch_c;
    logic [DATA_W-1:0] head_c;

    // FIFO status; pointers carry one extra wrap bit to tell full from empty
    always_comb begin
        empty_c = '0;
        full_c  = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            empty_c[c] = (wptr[c] == rptr[c]);
            full_c[c]  = (wptr[c][PW-1] != rptr[c][PW-1]) &&
                         (wptr[c][AW-1:0] == rptr[c][AW-1:0]);
        end
    end

    assign rx_in_range_c = ({1'b0, rx_src} < (CH_W+1)'(NUM_CH));
    assign rd_in_range_c = ({1'b0, rd_ch} < (CH_W+1)'(NUM_CH));
    assign head_c        = mem[rd_ch][rptr[rd_ch][AW-1:0]];
    assign same_ch_c     = pop_c && (rd_ch == rx_src);
    assign push_c        = rx_valid && rx_in_range_c && (!full_c[rx_src] || same_ch_c);
    assign drop_full_c   = rx_valid && rx_in_range_c && full_c[rx_src] && !same_ch_c;

    // Next-state and registered-output logic
    always_comb begin
        state_nx       = state;
        wait_cnt_nx    = wait_cnt;
        rd_ch_nx       = rd_ch;
        tx_valid_nx    = tx_valid;
        tx_dest_nx     = tx_dest;
        tx_data_nx     = tx_data;
        mode_nx        = addr_so_control;
        send_done_nx   = 1'b0;
        timeout_err_nx = 1'b0;
        recv_valid_nx  = 1'b0;
        recv_empty_nx  = 1'b0;
        recv_data_nx   = '0;
        pop_c          = 1'b0;
        case (state)
            IDLE: begin
                if (send_req) begin
                    state_nx    = SEND_WAIT;
                    tx_valid_nx = 1'b1;
                    tx_dest_nx  = send_dest;
                    tx_data_nx  = send_data;
                    wait_cnt_nx = '0;
                    mode_nx     = 2'd0;
                end else if (recv_req) begin
                    state_nx = RECV;
                    rd_ch_nx = recv_ch;
                    mode_nx  = 2'd1;
                end
            end
            SEND_WAIT: begin
                if (tx_ack) begin
                    tx_valid_nx  = 1'b0;
                    send_done_nx = 1'b1;
                    state_nx     = IDLE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    tx_valid_nx    = 1'b0;
                    timeout_err_nx = 1'b1;
                    state_nx       = IDLE;
                end else begin
                    wait_cnt_nx = wait_cnt + CW'(1);
                end
            end
            RECV: begin
                state_nx      = IDLE;
                recv_valid_nx = 1'b1;
                if (rd_in_range_c && !empty_c[rd_ch]) begin
                    recv_data_nx = head_c;
                    pop_c        = 1'b1;
                end else begin
                    recv_empty_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            rd_ch           <= '0;
            busy            <= 1'b0;
            send_done       <= 1'b0;
            timeout_err     <= 1'b0;
            recv_valid      <= 1'b0;
            recv_empty      <= 1'b0;
            recv_data       <= '0;
            addr_so_control <= 2'd0;
            tx_valid        <= 1'b0;
            tx_dest         <= '0;
            tx_data         <= '0;
        end else begin
            state           <= state_nx;
            wait_cnt        <= wait_cnt_nx;
            rd_ch           <= rd_ch_nx;
            busy            <= busy_nx;
            send_done       <= send_done_nx;
            timeout_err     <= timeout_err_nx;
            recv_valid      <= recv_valid_nx;
            recv_empty      <= recv_empty_nx;
            recv_data       <= recv_data_nx;
            addr_so_control <= mode_nx;
            tx_valid        <= tx_valid_nx;
            tx_dest         <= tx_dest_nx;
            tx_data         <= tx_data_nx;
        end
    end

    // FIFO pointers and sticky overflow flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
            end
            overflow <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (push_c && (rx_src == CH_W'(c)))
                    wptr[c] <= wptr[c] + PW'(1);
                if (pop_c && (rd_ch == CH_W'(c)))
                    rptr[c] <= rptr[c] + PW'(1);
                if (drop_full_c && (rx_src == CH_W'(c)))
                    overflow[c] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_c)
            mem[rx_src][wptr[rx_src][AW-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_net_so_controller.sv
// Bench for net_so_controller: TX handshake/timeout, RX FIFOs via a receive scoreboard.
module tb_net_so_controller;

    logic        clock, reset;
    logic        send_req, recv_req, tx_ack, rx_valid;
    logic [1:0]  send_dest, recv_ch, rx_src, tx_dest, addr_so_control;
    logic [31:0] send_data, rx_data, recv_data, tx_data;
    logic        busy, send_done, timeout_err, recv_valid, recv_empty, tx_valid;
    logic [3:0]  overflow;

    net_so_controller #(.DATA_W(32), .NUM_CH(4), .FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .send_req(send_req), .send_dest(send_dest), .send_data(send_data),
        .recv_req(recv_req), .recv_ch(recv_ch),
        .busy(busy), .send_done(send_done), .timeout_err(timeout_err),
        .recv_valid(recv_valid), .recv_empty(recv_empty), .recv_data(recv_data),
        .addr_so_control(addr_so_control),
        .tx_valid(tx_valid), .tx_dest(tx_dest), .tx_data(tx_data), .tx_ack(tx_ack),
        .rx_valid(rx_valid), .rx_src(rx_src), .rx_data(rx_data),
        .overflow(overflow)
    );

    typedef struct {
        logic        empty;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mq[4][$];
    logic [3:0]  ovf_m;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_done   = 0;
    int          n_to     = 0;
    int          n_rv     = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every recv_valid pulse
    always @(negedge clock) begin
        if (recv_valid) begin
            n_rv++;
            if (exp_q.size() == 0) begin
                check("recv_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("recv_empty", 64'(recv_empty), 64'(e.empty));
                check("recv_data", 64'(recv_data), 64'(e.data));
            end
        end
        if (send_done) n_done++;
        if (timeout_err) n_to++;
        if ((32'(recv_valid) + 32'(send_done) + 32'(timeout_err)) > 1)
            check("pulse_exclusive", 64'd1, 64'd0);
    end

    function automatic void model_push(input logic [1:0] ch, input logic [31:0] d);
        if (mq[ch].size() < 4) mq[ch].push_back(d);
        else ovf_m[ch] = 1'b1;
    endfunction

    task automatic rx_word(input logic [1:0] ch, input logic [31:0] d);
        rx_valid = 1'b1; rx_src = ch; rx_data = d;
        tick();
        rx_valid = 1'b0;
        model_push(ch, d);
    endtask

    task automatic do_recv(input logic [1:0] ch, input bit push_during, input logic [31:0] pd);
        exp_t e;
        recv_req = 1'b1; recv_ch = ch;
        tick();
        recv_req = 1'b0;
        check("recv_mode", 64'(addr_so_control), 64'd1);
        check("recv_busy", 64'(busy), 64'd1);
        if (mq[ch].size() > 0) begin
            e.empty = 1'b0; e.data = mq[ch].pop_front();
        end else begin
            e.empty = 1'b1; e.data = 32'd0;
        end
        exp_q.push_back(e);
        if (push_during) begin
            rx_valid = 1'b1; rx_src = ch; rx_data = pd;
            model_push(ch, pd);
        end
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic do_send(input logic [1:0] dest, input logic [31:0] d,
                           input int ack_after, output int vcyc);
        send_req = 1'b1; send_dest = dest; send_data = d;
        tick();
        send_req = 1'b0; send_data = 32'hDEAD_BEEF; send_dest = ~dest;
        check("tx_mode", 64'(addr_so_control), 64'd0);
        vcyc = 0;
        for (int i = 0; i < 50 && tx_valid; i++) begin
            check("tx_dest", 64'(tx_dest), 64'(dest));
            check("tx_data", 64'(tx_data), 64'(d));
            vcyc++;
            tx_ack = (vcyc == ack_after + 1);
            tick();
            tx_ack = 1'b0;
        end
        if (tx_valid) check("tx_stuck", 64'd1, 64'd0);
        tick();
    endtask

    initial begin
        int vc, d0, t0, r0;
        logic [31:0] old3 [4];
        reset = 1'b0; send_req = 1'b0; recv_req = 1'b0; tx_ack = 1'b0; rx_valid = 1'b0;
        send_dest = '0; recv_ch = '0; rx_src = '0; send_data = '0; rx_data = '0;
        ovf_m = '0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_mode", 64'(addr_so_control), 64'd0);
        check("rst_recv_valid", 64'(recv_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        reset = 1'b1;
        tick();

        // 1: acked send after 3 waiting cycles
        d0 = n_done; t0 = n_to;
        do_send(2'd2, 32'hCAFE_0001, 3, vc);
        check("t1_valid_cycles", 64'(vc), 64'd4);
        check("t1_done_pulses", 64'(n_done - d0), 64'd1);
        check("t1_no_timeout", 64'(n_to - t0), 64'd0);
        check("t1_busy_after", 64'(busy), 64'd0);

        // 2: timeout with no ack
        d0 = n_done; t0 = n_to;
        do_send(2'd1, 32'h1234_5678, -1, vc);
        check("t2_valid_cycles", 64'(vc), 64'd8);
        check("t2_timeout_pulses", 64'(n_to - t0), 64'd1);
        check("t2_no_done", 64'(n_done - d0), 64'd0);

        // 3: ordered reads then empty
        rx_word(2'd1, 32'h11); rx_word(2'd1, 32'h22); rx_word(2'd1, 32'h33);
        repeat (4) do_recv(2'd1, 1'b0, 32'h0);

        // 4: overflow on ch0
        for (int i = 0; i < 5; i++) rx_word(2'd0, 32'h100 + 32'(i));
        check("t4_overflow", 64'(overflow), 64'(ovf_m));
        repeat (4) do_recv(2'd0, 1'b0, 32'h0);
        check("t4_overflow_sticky", 64'(overflow), 64'd1);

        // 5: push on a full channel during its pop cycle
        for (int i = 0; i < 4; i++) begin
            old3[i] = 32'hA000 + 32'(i);
            rx_word(2'd3, old3[i]);
        end
        do_recv(2'd3, 1'b1, 32'hBEEF);
        check("t5_no_overflow", 64'(overflow), 64'(ovf_m));
        check("t5_ovf3_clear", 64'(overflow[3]), 64'd0);
        repeat (5) do_recv(2'd3, 1'b0, 32'h0);

        // 6: send beats recv; then reset during SEND_WAIT
        d0 = n_done; r0 = n_rv;
        send_req = 1'b1; recv_req = 1'b1; recv_ch = 2'd1; send_dest = 2'd3; send_data = 32'h5A5A;
        tick();
        send_req = 1'b0; recv_req = 1'b0;
        check("t6_tx_valid", 64'(tx_valid), 64'd1);
        check("t6_mode", 64'(addr_so_control), 64'd0);
        tx_ack = 1'b1; tick(); tx_ack = 1'b0;
        repeat (3) tick();
        check("t6_done", 64'(n_done - d0), 64'd1);
        check("t6_no_recv", 64'(n_rv - r0), 64'd0);

        rx_word(2'd2, 32'h77);
        send_req = 1'b1; send_dest = 2'd2; send_data = 32'h9999;
        tick();
        send_req = 1'b0;
        check("t6_tx_valid2", 64'(tx_valid), 64'd1);
        tick();
        reset = 1'b0;
        #1;
        check("t6_rst_tx_valid", 64'(tx_valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_tx_data", 64'(tx_data), 64'd0);
        check("t6_rst_overflow", 64'(overflow), 64'd0);
        for (int c = 0; c < 4; c++) mq[c].delete();
        ovf_m = '0;
        d0 = n_done; t0 = n_to;
        tick();
        reset = 1'b1;
        repeat (12) tick();
        check("t6_no_done_after", 64'(n_done - d0), 64'd0);
        check("t6_no_timeout_after", 64'(n_to - t0), 64'd0);
        do_recv(2'd2, 1'b0, 32'h0);

        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
